// File: rtl/opm_sample_fifo.sv
// opm_sample_fifo
// Stereo sample buffer between the OPM sound core and the I2S DAC interface.
// Each incoming YM3012 floating-point pair is converted to 16-bit linear PCM
// when it is written. The converted pair is queued in a small FIFO. One pair is
// handed to the DAC side per next_sample pulse, which absorbs the rate mismatch
// between the OPM sample clock and LRCK.

module opm_sample_fifo #(
  parameter int DEPTH_LOG2       = 3,
  parameter int MUTE_ON_UNDERRUN = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [12:0]           in_left,
  input  logic [12:0]           in_right,
  input  logic                  next_sample,
  output logic [23:0]           left_data,
  output logic [23:0]           right_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underrun,
  output logic                  overflow,
  input  logic                  clear_flags
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = DEPTH[DEPTH_LOG2:0];

  // One FIFO entry holds the already-converted pair: {left_lin16, right_lin16}.
  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } pair_t;

  // YM3012 float {mant[9:0], exp[2:0]} to 16-bit two's-complement linear.
  // The mantissa is offset binary, so flipping its MSB gives a signed value.
  // exp=0 is a hard mute. The largest shift (exp=7, by 6) spans -32768..+32704,
  // so the result never needs saturation.
  function automatic logic [15:0] ym_to_lin(input logic [12:0] flt);
    logic [9:0]  mant;
    logic [2:0]  expo;
    logic [15:0] s16;
    mant = flt[12:3];
    expo = flt[2:0];
    s16  = {{6{~mant[9]}}, ~mant[9], mant[8:0]};
    if (expo == 3'd0) begin
      return 16'h0000;
    end
    return s16 << (expo - 3'd1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  pair_t                 mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q,   wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q,   rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q,    level_d;
  pair_t                 out_q,      out_d;
  logic                  underrun_q, underrun_d;
  logic                  overflow_q, overflow_d;

  // Handshake decodes derived only from registered state and the inputs.
  logic  full;
  logic  empty;
  logic  push;
  logic  pop;
  logic  underrun_evt;
  logic  overflow_evt;
  pair_t wr_entry;
  pair_t head;

  // Decode push/pop and the flag-setting events for this cycle.
  always_comb begin
    full         = (level_q == FULL_LEVEL);
    empty        = (level_q == '0);
    // A full FIFO refuses the write even if a pop happens in the same cycle.
    // This keeps in_ready free of any combinational path from next_sample.
    push         = in_valid && !full;
    pop          = next_sample && !empty;
    underrun_evt = next_sample && empty;
    overflow_evt = in_valid && full;
    wr_entry     = '{left: ym_to_lin(in_left), right: ym_to_lin(in_right)};
    head         = mem_q[rd_ptr_q];
  end

  // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, otherwise synthesis infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Next-state for the DAC-facing output register.
  always_comb begin
    out_d = out_q;
    if (pop) begin
      out_d = head;
    end else if (underrun_evt && (MUTE_ON_UNDERRUN != 0)) begin
      out_d = '0;
    end
  end

  // Next-state for the sticky flags; a set event beats a same-cycle clear.
  always_comb begin
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (clear_flags) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (underrun_evt) begin
      underrun_d = 1'b1;
    end
    if (overflow_evt) begin
      overflow_d = 1'b1;
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_q      <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_q      <= out_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Sample storage, written on an accepted transfer.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Pointers and level define which
    // entries are valid, so stale contents are never observed. Leaving the
    // reset off also lets the array map onto plain RAM.
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Outputs are driven straight from registered state.
  always_comb begin
    in_ready   = !full;
    level      = level_q;
    left_data  = {out_q.left, 8'h00};
    right_data = {out_q.right, 8'h00};
    underrun   = underrun_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_opm_sample_fifo.sv
// Directed testbench for opm_sample_fifo.
// Two instances share one stimulus stream: u_dut repeats the last pair on
// underrun, and u_mute outputs zero on underrun.

module tb_opm_sample_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [12:0] in_left;
  logic [12:0] in_right;
  logic        next_sample;
  logic        clear_flags;

  logic        in_ready,    m_in_ready;
  logic [23:0] left_data,   m_left_data;
  logic [23:0] right_data,  m_right_data;
  logic [3:0]  level,       m_level;
  logic        underrun,    m_underrun;
  logic        overflow,    m_overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  opm_sample_fifo #(.DEPTH_LOG2(3), .MUTE_ON_UNDERRUN(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .next_sample(next_sample),
    .left_data(left_data), .right_data(right_data), .level(level),
    .underrun(underrun), .overflow(overflow), .clear_flags(clear_flags)
  );

  opm_sample_fifo #(.DEPTH_LOG2(3), .MUTE_ON_UNDERRUN(1)) u_mute (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_left(in_left), .in_right(in_right), .next_sample(next_sample),
    .left_data(m_left_data), .right_data(m_right_data), .level(m_level),
    .underrun(m_underrun), .overflow(m_overflow), .clear_flags(clear_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, starting and ending at a falling edge.
  task automatic step(input logic v, input logic [12:0] l, input logic [12:0] r,
                      input logic ns, input logic clr);
    in_valid    = v;
    in_left     = l;
    in_right    = r;
    next_sample = ns;
    clear_flags = clr;
    @(negedge clk);
    in_valid    = 1'b0;
    next_sample = 1'b0;
    clear_flags = 1'b0;
  endtask

  // Test pair k: left mant 0x200+k, exp 1 gives +k. Right mant 0x200-k, exp 2
  // gives -2k.
  function automatic logic [12:0] pat_l(input int k);
    logic [9:0] m;
    m = 10'h200 + 10'(k);
    return {m, 3'd1};
  endfunction
  function automatic logic [12:0] pat_r(input int k);
    logic [9:0] m;
    m = 10'h200 - 10'(k);
    return {m, 3'd2};
  endfunction
  function automatic logic [23:0] exp_l(input int k);
    return 24'(k * 256);
  endfunction
  function automatic logic [23:0] exp_r(input int k);
    return 24'(32'h0100_0000 - k * 512);
  endfunction

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_left     = '0;
    in_right    = '0;
    next_sample = 1'b0;
    clear_flags = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_level",    32'(level),      32'd0);
    check("rst_left",     32'(left_data),  32'h0);
    check("rst_right",    32'(right_data), 32'h0);
    check("rst_underrun", 32'(underrun),   32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    check("rst_in_ready", 32'(in_ready),   32'd1);

    // 1: first pulse with an empty FIFO delivers zero and flags underrun
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t1_left",     32'(left_data),  32'h000000);
    check("t1_right",    32'(right_data), 32'h000000);
    check("t1_underrun", 32'(underrun),   32'd1);
    check("t1_level",    32'(level),      32'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("t1_clr", 32'(underrun), 32'd0);

    // 2: full-scale positive and negative, then underrun holds the value
    step(1'b1, {10'h3FF, 3'd7}, {10'h000, 3'd7}, 1'b0, 1'b0);
    check("t2_level_wr", 32'(level), 32'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t2_left",     32'(left_data),  32'h7FC000);
    check("t2_right",    32'(right_data), 32'h800000);
    check("t2_level_rd", 32'(level),      32'd0);
    check("t2_no_urun",  32'(underrun),   32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t2_urun",      32'(underrun),   32'd1);
    check("t2_hold_left", 32'(left_data),  32'h7FC000);
    check("t2_hold_right",32'(right_data), 32'h800000);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // 3: zero mantissa and exp=0 both give zero
    step(1'b1, {10'h200, 3'd4}, {10'h155, 3'd0}, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t3_left",  32'(left_data),  32'h000000);
    check("t3_right", 32'(right_data), 32'h000000);

    // 4: fill to full, ninth write overflows and is dropped
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, pat_l(k), pat_r(k), 1'b0, 1'b0);
      if (k == 7) check("t4_ready_at7", 32'(in_ready), 32'd1);
    end
    check("t4_level8",   32'(level),    32'd8);
    check("t4_ready8",   32'(in_ready), 32'd0);
    check("t4_no_ovf",   32'(overflow), 32'd0);
    step(1'b1, pat_l(9), pat_r(9), 1'b0, 1'b0);
    check("t4_ovf",      32'(overflow), 32'd1);
    check("t4_level9",   32'(level),    32'd8);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      check($sformatf("t4_pop%0d_l", k), 32'(left_data),  32'(exp_l(k)));
      check($sformatf("t4_pop%0d_r", k), 32'(right_data), 32'(exp_r(k)));
    end
    check("t4_level0", 32'(level), 32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t4_drop_urun", 32'(underrun),  32'd1);
    check("t4_drop_hold", 32'(left_data), 32'(exp_l(8)));
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("t4_clr_u", 32'(underrun), 32'd0);
    check("t4_clr_o", 32'(overflow), 32'd0);

    // 5: full FIFO with write and pop together: pop only, overflow set
    for (int k = 1; k <= 8; k++) step(1'b1, pat_l(k), pat_r(k), 1'b0, 1'b0);
    step(1'b1, pat_l(9), pat_r(9), 1'b1, 1'b0);
    check("t5_level7", 32'(level),     32'd7);
    check("t5_ovf",    32'(overflow),  32'd1);
    check("t5_head",   32'(left_data), 32'(exp_l(1)));
    for (int k = 2; k <= 4; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t5_level4", 32'(level), 32'd4);
    step(1'b1, pat_l(10), pat_r(10), 1'b1, 1'b0);
    check("t5_wrpop_level", 32'(level),     32'd4);
    check("t5_wrpop_left",  32'(left_data), 32'(exp_l(5)));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t5_p6", 32'(left_data), 32'(exp_l(6)));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t5_p8", 32'(left_data), 32'(exp_l(8)));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t5_p10_l", 32'(left_data),  32'(exp_l(10)));
    check("t5_p10_r", 32'(right_data), 32'(exp_r(10)));
    check("t5_empty", 32'(level), 32'd0);

    // 6: underrun in mute mode zeroes outputs; repeat mode holds them
    check("t6_mute_pre", 32'(m_left_data), 32'h000A00);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t6_mute_l",    32'(m_left_data),  32'h000000);
    check("t6_mute_r",    32'(m_right_data), 32'h000000);
    check("t6_mute_urun", 32'(m_underrun),   32'd1);
    check("t6_mute_ovf",  32'(m_overflow),   32'd1);
    check("t6_hold_l",    32'(left_data),    32'h000A00);
    check("t6_hold_r",    32'(right_data),   32'hFFEC00);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("t6_clr_u", 32'(m_underrun), 32'd0);
    check("t6_clr_o", 32'(m_overflow), 32'd0);
    // A set event in the same cycle as clear_flags wins
    step(1'b0, '0, '0, 1'b1, 1'b1);
    check("t6_set_wins", 32'(underrun), 32'd1);

    // Reset mid-stream takes effect immediately
    step(1'b1, pat_l(3), pat_r(3), 1'b0, 1'b0);
    step(1'b1, pat_l(4), pat_r(4), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t6_pre_rst_l",     32'(left_data), 32'(exp_l(3)));
    check("t6_pre_rst_level", 32'(level),     32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_left",  32'(left_data),  32'h0);
    check("t6_rst_right", 32'(right_data), 32'h0);
    check("t6_rst_level", 32'(level),      32'd0);
    check("t6_rst_urun",  32'(underrun),   32'd0);
    check("t6_rst_ready", 32'(in_ready),   32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    step(1'b1, pat_l(7), pat_r(7), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t6_post_rst_l", 32'(left_data), 32'(exp_l(7)));
    check("t6_post_rst_r", 32'(right_data), 32'(exp_r(7)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
